// File: rtl/reg30_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : reg30_serial_tx
// Purpose  : Buffers bytes written through CPU register 30 in a small FIFO
//            and serialises them on a UART line (8N1 by default).
//            A byte is queued whenever reg30_out[8] differs from its value
//            in the previous cycle; reg30_out[7:0] carries the byte.
// Options  : define REG30_SERIAL_TX_PARITY_EN to add an even-parity bit
//            between the data bits and the stop bit (8E1 framing).
// Params   : CLKS_PER_BIT >= 2, FIFO_DEPTH a power of two >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module reg30_serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 reg30_out,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef REG30_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               tx_q, tx_d;
  logic               prev_toggle_q, prev_toggle_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         drop_q, drop_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];

  logic push, pop, wr_en, drop, full, fifo_empty, baud_last;

  // Upper register bits carry no meaning for this block.
  logic unused_reg30_hi;
  assign unused_reg30_hi = ^reg30_out[31:9];

  // Push/pop decisions; pop only happens when a new frame may begin.
  always_comb begin
    push       = reg30_out[8] ^ prev_toggle_q;
    fifo_empty = (count_q == '0);
    full       = (count_q == CNT_FULL);
    baud_last  = (baud_q == BAUD_LAST);
    pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
  end

  // FIFO bookkeeping: pointers, occupancy, overflow counter and storage.
  always_comb begin
    prev_toggle_d = reg30_out[8];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    drop_d        = drop_q;
    mem_d         = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = reg30_out[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Framing FSM next state; tx is computed one cycle ahead so it is registered.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    // Every state or bit change happens on the last baud tick, so wrapping here
    // restarts the counter at each change.
    baud_d  = baud_last ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (pop) begin
          state_d = START;
          data_d  = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
`ifdef REG30_SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
`ifdef REG30_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          if (pop) begin
            // Next byte already waiting: start bit follows the stop bit directly.
            state_d = START;
            data_d  = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control state with asynchronous reset; tx returns high as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      data_q        <= '0;
      tx_q          <= 1'b1;
      prev_toggle_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      data_q        <= data_d;
      tx_q          <= tx_d;
      prev_toggle_q <= prev_toggle_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
    end
  end

  // FIFO storage needs no reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_reg30_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg30_serial_tx
// Purpose  : Self-checking bench for reg30_serial_tx (CLKS_PER_BIT=4,
//            FIFO_DEPTH=4). Table-driven single-byte frame, directed corner
//            sequences and random traffic against a byte-queue/frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg30_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef REG30_SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] reg30 = 32'h0;
  logic        tx, busy, fifo_full;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  reg30_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst),
    .reg30_out  (reg30),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: byte queue + frame timer ----------------
  byte unsigned mq[$];
  logic         m_prev;
  int           m_drop;
  bit           m_inf;     // a frame is on the line
  int           m_t;       // cycles since the start bit began
  logic [7:0]   m_cur;

  task automatic model_reset();
    mq.delete();
    m_prev = 1'b0;
    m_drop = 0;
    m_inf  = 1'b0;
    m_t    = 0;
    m_cur  = 8'h00;
  endtask

  task automatic model_step(input logic [31:0] din);
    bit pop, push, was_full;
    pop      = (mq.size() != 0) && (!m_inf || (m_t == FRAME - 1));
    push     = (din[8] != m_prev);
    was_full = (mq.size() == DEPTH);
    if (pop) begin
      m_cur = mq.pop_front();
      m_inf = 1'b1;
      m_t   = 0;
    end else if (m_inf) begin
      if (m_t == FRAME - 1) m_inf = 1'b0;
      else m_t++;
    end
    if (push) begin
      if (was_full && !pop) begin
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back(din[7:0]);
      end
    end
    m_prev = din[8];
  endtask

  function automatic logic model_tx();
    int slot;
    if (!m_inf) return 1'b1;
    slot = m_t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
`ifdef REG30_SERIAL_TX_PARITY_EN
    if (slot == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".tx"},    32'(tx),         32'(model_tx()));
    chk({tag, ".busy"},  32'(busy),       32'(m_inf || (mq.size() != 0)));
    chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, ".full"},  32'(fifo_full),  32'(mq.size() == DEPTH));
    chk({tag, ".drop"},  32'(drop_count), 32'(m_drop));
  endtask

  // Drive one cycle of input, advance model at the edge, compare at negedge.
  task automatic step(input logic [31:0] din, input string tag);
    reg30 = din;
    @(posedge clk);
    model_step(din);
    @(negedge clk);
    cmp_model(tag);
  endtask

  task automatic drain(input int maxc, input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < maxc)) begin
      step(reg30, tag);
      n++;
    end
    chk({tag, ".drained"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset(input logic [31:0] hold, input int n);
    rst   = 1'b1;
    reg30 = hold;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      chk("rst.tx",    32'(tx),         32'd1);
      chk("rst.busy",  32'(busy),       32'd0);
      chk("rst.count", 32'(fifo_count), 32'd0);
      chk("rst.drop",  32'(drop_count), 32'd0);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] din;
    logic        tx;
    logic        busy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t       vt[$];
  vec_t       v;
  logic [7:0] sb;
  int         busy_n, peak, bursts;
  bit         full_seen;
  logic [31:0] din;

  initial begin
    // ---- table for the single-byte 0x55 frame ----
    sb = 8'h55;
    v = '{32'h0000_0155, 1'b1, 1'b1, 3'd1};          // queued, not yet on the line
    vt.push_back(v);
    for (int j = 0; j < FRAME; j++) begin
      int   slot;
      logic e;
      slot = j / CPB;
      if (slot == 0)      e = 1'b0;
      else if (slot <= 8) e = sb[slot-1];
`ifdef REG30_SERIAL_TX_PARITY_EN
      else if (slot == 9) e = ^sb;
`endif
      else                e = 1'b1;
      v = '{32'h0000_0155, e, 1'b1, 3'd0};
      vt.push_back(v);
    end
    v = '{32'h0000_0155, 1'b1, 1'b0, 3'd0};          // frame over, line idle
    vt.push_back(v);

    // ---- reset held 3 cycles, then quiet ----
    apply_reset(32'h0, 3);
    for (int i = 0; i < 5; i++) step(32'h0, "idle");

    // ---- single byte, table-driven ----
    foreach (vt[i]) begin
      reg30 = vt[i].din;
      @(posedge clk);
      model_step(vt[i].din);
      @(negedge clk);
      chk($sformatf("tbl%0d.tx", i),    32'(tx),         32'(vt[i].tx));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),       32'(vt[i].busy));
      chk($sformatf("tbl%0d.count", i), 32'(fifo_count), 32'(vt[i].cnt));
    end

    // ---- back-to-back: three bytes on consecutive cycles ----
    busy_n = 0;
    peak   = 0;
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      if (i == 0)      din = 32'h0000_00A5;
      else if (i == 1) din = 32'h0000_013C;
      else             din = 32'h0000_00FF;
      step(din, "b2b");
      if (busy === 1'b1) busy_n++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("b2b.peak", 32'(peak), 32'd2);
    chk("b2b.busy_cycles", 32'(busy_n), 32'(3 * FRAME + 1));

    // ---- overflow: six toggles in six cycles ----
    full_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      din = 32'(i) | ((i % 2 == 1) ? 32'h100 : 32'h0);
      step(din, "ovf");
      if (fifo_full === 1'b1) full_seen = 1'b1;
    end
    chk("ovf.full_seen", 32'(full_seen), 32'd1);
    chk("ovf.drop", 32'(drop_count), 32'd1);
    chk("ovf.count", 32'(fifo_count), 32'd4);
    drain(6 * FRAME, "ovf");

    // ---- data/upper bits change, toggle bit constant ----
    for (int i = 0; i < 50; i++) begin
      din = $urandom() & ~32'h100;
      step(din, "notog");
      chk("notog.count", 32'(fifo_count), 32'd0);
      chk("notog.tx", 32'(tx), 32'd1);
    end

    // ---- reset during data bit 3 of 0x55 with two more bytes queued ----
    step(32'h0000_0155, "rmf");
    step(32'h0000_00AA, "rmf");
    step(32'h0000_0133, "rmf");
    begin
      int n;
      n = 0;
      while (!(m_inf && (m_t / CPB == 4)) && (n < 40)) begin
        step(32'h0000_0133, "rmf");
        n++;
      end
      chk("rmf.reached_bit3", 32'(n < 40), 32'd1);
    end
    chk("rmf.tx_bit3", 32'(tx), 32'd0);
    chk("rmf.queued", 32'(fifo_count), 32'd2);
    #2;
    rst   = 1'b1;
    reg30 = 32'h0;
    #1;
    chk("rmf.async_tx", 32'(tx), 32'd1);
    chk("rmf.async_count", 32'(fifo_count), 32'd0);
    chk("rmf.async_busy", 32'(busy), 32'd0);
    apply_reset(32'h0, 3);
    for (int i = 0; i < 20; i++) begin
      step(32'h0, "rmf.after");
      chk("rmf.after.tx", 32'(tx), 32'd1);
      chk("rmf.after.count", 32'(fifo_count), 32'd0);
    end

    // ---- toggle bit already high on the first cycle after release ----
    apply_reset(32'h0000_017E, 2);
    step(32'h0000_017E, "rel");
    chk("rel.count", 32'(fifo_count), 32'd1);
    drain(2 * FRAME, "rel");

    // ---- random traffic: sparse toggles with periodic dense bursts ----
    din    = 32'h0000_017E;
    bursts = 0;
    for (int c = 0; c < 1500; c++) begin
      int unsigned pct;
      pct = (c % 300 < 20) ? 2 : 40;
      din[31:9] = 23'($urandom());
      din[7:0]  = 8'($urandom());
      if ($urandom_range(pct - 1, 0) == 0) din[8] = ~din[8];
      step(din, "rnd");
      if (fifo_full === 1'b1) bursts++;
    end
    drain(6 * FRAME, "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
